// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, alignment check,
// lane steering for stores, extension for loads, pipeline stall while in flight.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  // Request handshake: a request transfers on a rising edge where
  // ReqValid && ReqReady; ReqReady is high only in IDLE, and the response
  // is a single-cycle RspValid pulse that needs no acknowledge.
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        AlignErr,
  output logic        Stall,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemRData,
  output logic [1:0]  DbgState
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] LAT_M1 = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

  logic [1:0]  state;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        err;
  logic [3:0]  cnt;
  logic [31:0] rword;
  logic        misaligned;

  assign misaligned = ((ReqSize == 2'b00) && (ReqAddr[1:0] != 2'b00)) ||
                      ((ReqSize == 2'b01) && ReqAddr[0]) ||
                      (ReqSize == 2'b11);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      req_write <= 1'b0;
      req_size  <= 2'b00;
      req_uns   <= 1'b0;
      req_addr  <= 32'd0;
      req_data  <= 32'd0;
      err       <= 1'b0;
      cnt       <= 4'd0;
      rword     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ReqValid) begin
            req_write <= ReqWrite;
            req_size  <= ReqSize;
            req_uns   <= ReqUnsigned;
            req_addr  <= ReqAddr;
            req_data  <= ReqData;
            err       <= misaligned;
            rword     <= 32'd0;
            state     <= misaligned ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (MEM_LAT == 0) begin
            if (!req_write) rword <= MemRData;
            state <= S_DONE;
          end else begin
            cnt   <= LAT_M1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            if (!req_write) rword <= MemRData;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic        in_access;
  logic        in_done;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign in_access = (state == S_ACCESS);
  assign in_done   = (state == S_DONE);

  always_comb begin
    be    = 4'b0000;
    wdata = 32'd0;
    case (req_size)
      2'b00: begin
        be    = 4'b1111;
        wdata = req_data;
      end
      2'b01: begin
        be    = 4'b0011 << {req_addr[1], 1'b0};
        wdata = {2{req_data[15:0]}};
      end
      2'b10: begin
        be    = 4'b0001 << req_addr[1:0];
        wdata = {4{req_data[7:0]}};
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'd0;
      end
    endcase
  end

  assign ld_byte = rword[{req_addr[1:0], 3'b000} +: 8];
  assign ld_half = rword[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = 32'd0;
    case (req_size)
      2'b00:   ld_ext = rword;
      2'b01:   ld_ext = {{16{~req_uns & ld_half[15]}}, ld_half};
      2'b10:   ld_ext = {{24{~req_uns & ld_byte[7]}}, ld_byte};
      default: ld_ext = 32'd0;
    endcase
  end

  // Memory-side outputs are qualified by ACCESS so they read as zero otherwise,
  // which also makes an asynchronous reset drop the strobe at once.
  assign MemRead  = in_access & ~req_write;
  assign MemWrite = in_access & req_write;
  assign MemAddr  = in_access ? {req_addr[31:2], 2'b00} : 32'd0;
  assign MemBE    = in_access ? be : 4'b0000;
  assign MemWData = in_access ? wdata : 32'd0;

  assign ReqReady = (state == S_IDLE);
  assign Stall    = in_access | (state == S_WAIT) | ((state == S_IDLE) & ReqValid);
  assign RspValid = in_done;
  assign AlignErr = in_done & err;
  assign RspData  = (in_done && !req_write && !err) ? ld_ext : 32'd0;
  assign DbgState = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table on a MEM_LAT=1 instance,
// plus latency, back-to-back and reset-abort sequences.
`timescale 1ns/1ps
module tb_load_store_unit;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rsp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  // shared request fields
  logic        ReqValid, rv_b;
  logic        ReqWrite, ReqUnsigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqData, MemRData;

  // MEM_LAT = 1 instance
  logic        ReqReady, RspValid, AlignErr, Stall, MemWrite, MemRead;
  logic [31:0] RspData, MemAddr, MemWData;
  logic [3:0]  MemBE;
  logic [1:0]  DbgState;

  // MEM_LAT = 0 and MEM_LAT = 3 instances
  logic        rdy_0, rv_0, ae_0, st_0, mw_0, mr_0;
  logic [31:0] rd_0, ma_0, wd_0;
  logic [3:0]  be_0;
  logic [1:0]  ds_0;
  logic        rdy_3, rv_3, ae_3, st_3, mw_3, mr_3;
  logic [31:0] rd_3, ma_3, wd_3;
  logic [3:0]  be_3;
  logic [1:0]  ds_3;

  load_store_unit #(.MEM_LAT(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspValid(RspValid), .RspData(RspData),
    .AlignErr(AlignErr), .Stall(Stall), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemBE(MemBE), .MemWrite(MemWrite), .MemRead(MemRead), .MemRData(MemRData),
    .DbgState(DbgState)
  );

  load_store_unit #(.MEM_LAT(0)) u_lat0 (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(rv_b), .ReqReady(rdy_0),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspValid(rv_0), .RspData(rd_0),
    .AlignErr(ae_0), .Stall(st_0), .MemAddr(ma_0), .MemWData(wd_0),
    .MemBE(be_0), .MemWrite(mw_0), .MemRead(mr_0), .MemRData(MemRData),
    .DbgState(ds_0)
  );

  load_store_unit #(.MEM_LAT(3)) u_lat3 (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(rv_b), .ReqReady(rdy_3),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspValid(rv_3), .RspData(rd_3),
    .AlignErr(ae_3), .Stall(st_3), .MemAddr(ma_3), .MemWData(wd_3),
    .MemBE(be_3), .MemWrite(mw_3), .MemRead(mr_3), .MemRData(MemRData),
    .DbgState(ds_3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] r);
    ReqWrite    = w;
    ReqSize     = sz;
    ReqUnsigned = u;
    ReqAddr     = a;
    ReqData     = d;
    MemRData    = r;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int extra;
    @(negedge Clk);
    drive_req(v.write, v.size, v.uns, v.addr, v.wdata, v.rdata);
    ReqValid = 1'b1;
    #1;
    chk($sformatf("v%0d_ready", idx), 32'(ReqReady), 32'd1);
    chk($sformatf("v%0d_stall_req", idx), 32'(Stall), 32'd1);
    @(negedge Clk);
    ReqValid = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d_rspvalid", idx), 32'(RspValid), 32'd1);
      chk($sformatf("v%0d_alignerr", idx), 32'(AlignErr), 32'd1);
      chk($sformatf("v%0d_rspdata", idx), RspData, 32'd0);
      chk($sformatf("v%0d_strobe", idx), 32'({MemRead, MemWrite}), 32'd0);
      chk($sformatf("v%0d_be", idx), 32'(MemBE), 32'd0);
      chk($sformatf("v%0d_stall_done", idx), 32'(Stall), 32'd0);
    end else begin
      chk($sformatf("v%0d_memread", idx), 32'(MemRead), 32'(!v.write));
      chk($sformatf("v%0d_memwrite", idx), 32'(MemWrite), 32'(v.write));
      chk($sformatf("v%0d_memaddr", idx), MemAddr, v.maddr);
      chk($sformatf("v%0d_be", idx), 32'(MemBE), 32'(v.be));
      if (v.write) chk($sformatf("v%0d_wdata", idx), MemWData, v.mwdata);
      chk($sformatf("v%0d_stall_acc", idx), 32'(Stall), 32'd1);
      lat = 1;
      extra = 0;
      while (!RspValid && lat < 20) begin
        @(negedge Clk);
        lat++;
        if (MemRead || MemWrite) extra++;
      end
      exp_q.push_back(v.rsp);
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
      chk($sformatf("v%0d_rspdata", idx), RspData, exp_q.pop_front());
      chk($sformatf("v%0d_alignerr", idx), 32'(AlignErr), 32'd0);
      chk($sformatf("v%0d_stall_done", idx), 32'(Stall), 32'd0);
      chk($sformatf("v%0d_extra_strobes", idx), 32'(extra), 32'd0);
    end
    @(negedge Clk);
    chk($sformatf("v%0d_rsp_pulse", idx), 32'(RspValid), 32'd0);
    chk($sformatf("v%0d_ready_after", idx), 32'(ReqReady), 32'd1);
  endtask

  vec_t vecs[16];

  initial begin
    int lat0, lat3, rd_cnt3, rsp_seen;
    logic [31:0] d0, d3;

    //            wr  sz    un  addr          wdata         rdata         err  maddr         be       mwdata        rsp
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h80FF0102, 1'b0, 32'h10, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 2'd2, 1'b1, 32'h13, 32'h0,        32'h80FF0102, 1'b0, 32'h10, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h80FF0102, 1'b0, 32'h10, 4'b1100, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h80FF0102, 1'b0, 32'h10, 4'b0011, 32'h0,        32'h00000102};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h80FF0102, 1'b0, 32'h10, 4'b0010, 32'h0,        32'h00000001};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h80FF0102, 1'b0, 32'h10, 4'b0100, 32'h0,        32'hFFFFFFFF};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h21, 32'h123456AB, 32'hFFFFFFFF, 1'b0, 32'h20, 4'b0010, 32'hABABABAB, 32'h0};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234, 32'hFFFFFFFF, 1'b0, 32'h20, 4'b1100, 32'h12341234, 32'h0};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h30, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 32'h30, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h06, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h0,  4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h0,  4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h0,  4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h02, 32'h55,       32'hFFFFFFFF, 1'b1, 32'h0,  4'b0000, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h01, 32'h55,       32'hFFFFFFFF, 1'b1, 32'h0,  4'b0000, 32'h0,        32'h0};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0,        32'h7FFF8000, 1'b0, 32'h14, 4'b1100, 32'h0,        32'h00007FFF};

    // reset
    Rst_n = 1'b0;
    ReqValid = 1'b0;
    rv_b = 1'b0;
    drive_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_ready", 32'(ReqReady), 32'd1);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_rspvalid", 32'(RspValid), 32'd0);
    chk("rst_alignerr", 32'(AlignErr), 32'd0);
    chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    chk("rst_be", 32'(MemBE), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_wdata", MemWData, 32'd0);
    chk("rst_rspdata", RspData, 32'd0);
    chk("rst_state", 32'(DbgState), 32'd0);
    Rst_n = 1'b1;

    // vector table on MEM_LAT=1
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // latency comparison: MEM_LAT=0 and MEM_LAT=3 get the same load
    @(negedge Clk);
    drive_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h13579BDF);
    rv_b = 1'b1;
    @(negedge Clk);
    rv_b = 1'b0;
    lat0 = -1;
    lat3 = -1;
    rd_cnt3 = 0;
    d0 = 32'd0;
    d3 = 32'd0;
    for (int n = 1; n <= 15; n++) begin
      if (rv_0 && lat0 < 0) begin lat0 = n; d0 = rd_0; end
      if (rv_3 && lat3 < 0) begin lat3 = n; d3 = rd_3; end
      if (mr_3) rd_cnt3++;
      if (n < 15) @(negedge Clk);
    end
    chk("lat0_latency", 32'(lat0), 32'd2);
    chk("lat0_rspdata", d0, 32'h13579BDF);
    chk("lat3_latency", 32'(lat3), 32'd5);
    chk("lat3_rspdata", d3, 32'h13579BDF);
    chk("lat3_read_strobes", 32'(rd_cnt3), 32'd1);

    // back-to-back with ReqValid held high on MEM_LAT=1
    @(negedge Clk);
    drive_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0BADF00D);
    ReqValid = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_c%0d_ready", i), 32'(ReqReady), 32'((i % 4) == 0));
      chk($sformatf("b2b_c%0d_memread", i), 32'(MemRead), 32'((i % 4) == 1));
      chk($sformatf("b2b_c%0d_rspvalid", i), 32'(RspValid), 32'((i % 4) == 3));
      chk($sformatf("b2b_c%0d_stall", i), 32'(Stall), 32'((i % 4) != 3));
      if ((i % 4) == 3) chk($sformatf("b2b_c%0d_rspdata", i), RspData, 32'h0BADF00D);
      if (i == 7) ReqValid = 1'b0;
      @(negedge Clk);
    end

    // reset during WAIT aborts the request
    drive_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h11111111);
    ReqValid = 1'b1;
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    chk("abort_in_wait", 32'(DbgState), 32'd2);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({MemRead, MemWrite}), 32'd0);
    chk("abort_rspvalid", 32'(RspValid), 32'd0);
    chk("abort_stall", 32'(Stall), 32'd0);
    chk("abort_ready", 32'(ReqReady), 32'd1);
    chk("abort_memaddr", MemAddr, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (RspValid) rsp_seen++;
    end
    chk("abort_no_rsp", 32'(rsp_seen), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
